gpio_serial_loader: RTL and testbench

GPIO_SERIAL_LOADER -- requirements
Module: gpio_serial_loader

---
 rtl/gpio_serial_loader.sv | 163 ++++++++++++++++
 tb/tb_gpio_serial_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_serial_loader.sv
// Per-pad configuration store that shifts its contents into a gpio_control_block chain, then pulses load.
// Defining GPIO_LOADER_READBACK_EN adds a registered cfg_rdata readback port (1-cycle latency).
module gpio_serial_loader #(
    parameter int NUM_GPIO      = 38,
    parameter int PAD_CTRL_BITS = 13,
    parameter int CLK_DIV       = 2,
    localparam int ADDR_W       = (NUM_GPIO > 1) ? $clog2(NUM_GPIO) : 1
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,
    input  logic [NUM_GPIO*PAD_CTRL_BITS-1:0] gpio_defaults,
    input  logic                              cfg_wr,
    input  logic [ADDR_W-1:0]                 cfg_addr,
    input  logic [PAD_CTRL_BITS-1:0]          cfg_wdata,
    output logic [PAD_CTRL_BITS-1:0]          cfg_rdata,
    output logic                              wr_reject,
    input  logic                              xfer_start,
    output logic                              busy,
    output logic                              done,
    output logic                              serial_clock,
    output logic                              serial_data,
    output logic                              serial_load,
    output logic                              serial_resetn
);

    localparam int TOTAL = NUM_GPIO * PAD_CTRL_BITS;
    localparam int BIT_W = $clog2(TOTAL + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(TOTAL - 1);
    localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(NUM_GPIO);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t                   r_state, w_state_nxt;
    logic [DIV_W-1:0]         r_div, w_div_nxt;
    logic [BIT_W-1:0]         r_bit, w_bit_nxt;
    logic                     r_phase, w_phase_nxt;
    logic                     w_load_end;
    logic [PAD_CTRL_BITS-1:0] r_cfg [NUM_GPIO];
    logic [TOTAL-1:0]         w_flat;
    logic [BIT_W-1:0]         w_idx;
    logic                     w_addr_ok;
    logic                     w_wr_ok;
    logic                     r_wr_reject;
    logic                     r_done;
    logic                     r_resetn;

    assign w_addr_ok = {1'b0, cfg_addr} < ADDR_LIM;
    assign w_wr_ok   = cfg_wr && (r_state == IDLE) && w_addr_ok;

    // Storage cannot change while busy, so SHIFT can index it directly instead of copying it out.
    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_flat
        assign w_flat[g*PAD_CTRL_BITS +: PAD_CTRL_BITS] = r_cfg[g];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_phase_nxt = r_phase;
        w_load_end  = 1'b0;
        case (r_state)
            IDLE: begin
                if (xfer_start) begin
                    w_state_nxt = SHIFT;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_phase_nxt = 1'b0;
                end
            end
            SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div_nxt = '0;
                    if (!r_phase) begin
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = 1'b0;
                        if (r_bit == BIT_LAST) begin
                            w_state_nxt = LOAD;
                            w_bit_nxt   = '0;
                        end else begin
                            w_bit_nxt = r_bit + 1'b1;
                        end
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            LOAD: begin
                if (r_div == DIV_LAST) begin
                    w_state_nxt = IDLE;
                    w_div_nxt   = '0;
                    w_load_end  = 1'b1;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_phase     <= 1'b0;
            r_done      <= 1'b0;
            r_wr_reject <= 1'b0;
            r_resetn    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_bit       <= w_bit_nxt;
            r_phase     <= w_phase_nxt;
            r_done      <= w_load_end;
            r_wr_reject <= cfg_wr && !w_wr_ok;
            r_resetn    <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int k = 0; k < NUM_GPIO; k++) begin
                r_cfg[k] <= gpio_defaults[k*PAD_CTRL_BITS +: PAD_CTRL_BITS];
            end
        end else begin
            for (int k = 0; k < NUM_GPIO; k++) begin
                if (w_wr_ok && (cfg_addr == ADDR_W'(k))) begin
                    r_cfg[k] <= cfg_wdata;
                end
            end
        end
    end

    // Highest pad, MSB first: pad NUM_GPIO-1 ends up furthest down the chain.
    assign w_idx         = BIT_LAST - r_bit;
    assign busy          = (r_state != IDLE);
    assign serial_clock  = (r_state == SHIFT) && r_phase;
    assign serial_data   = (r_state == SHIFT) && w_flat[w_idx];
    assign serial_load   = (r_state == LOAD);
    assign serial_resetn = r_resetn;
    assign done          = r_done;
    assign wr_reject     = r_wr_reject;

`ifdef GPIO_LOADER_READBACK_EN
    logic [PAD_CTRL_BITS-1:0] r_rdata;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_addr_ok ? r_cfg[cfg_addr] : '0;
        end
    end

    assign cfg_rdata = r_rdata;
`else
    assign cfg_rdata = '0;
`endif

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Bench for gpio_serial_loader: a two-pad gpio_control_block chain model plus a 3-pad, CLK_DIV=2 instance.
module tb_gpio_serial_loader;

    logic        clk;
    logic        rst;
    logic [25:0] gpio_defaults;
    logic        cfg_wr;
    logic [0:0]  cfg_addr;
    logic [12:0] cfg_wdata;
    logic [12:0] cfg_rdata;
    logic        wr_reject;
    logic        xfer_start;
    logic        busy, done;
    logic        serial_clock, serial_data, serial_load, serial_resetn;

    logic [38:0] gpio_defaults3;
    logic        cfg_wr3;
    logic [1:0]  cfg_addr3;
    logic [12:0] cfg_rdata3;
    logic        wr_reject3, xfer3, busy3, done3;
    logic        sclk3, sdata3, sload3, srstn3;

    int n_checks = 0;
    int n_err    = 0;
    int load_cnt = 0;

    gpio_serial_loader #(.NUM_GPIO(2), .PAD_CTRL_BITS(13), .CLK_DIV(1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .gpio_defaults(gpio_defaults),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .wr_reject(wr_reject), .xfer_start(xfer_start),
        .busy(busy), .done(done), .serial_clock(serial_clock),
        .serial_data(serial_data), .serial_load(serial_load),
        .serial_resetn(serial_resetn)
    );

    gpio_serial_loader #(.NUM_GPIO(3), .PAD_CTRL_BITS(13), .CLK_DIV(2)) dut3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .gpio_defaults(gpio_defaults3),
        .cfg_wr(cfg_wr3), .cfg_addr(cfg_addr3), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata3), .wr_reject(wr_reject3), .xfer_start(xfer3),
        .busy(busy3), .done(done3), .serial_clock(sclk3),
        .serial_data(sdata3), .serial_load(sload3), .serial_resetn(srstn3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain model: pad0 receives serial_data, its MSB feeds pad1.
    logic [12:0] sh0, sh1, ld0, ld1;
    logic [25:0] stream;

    always @(posedge serial_clock or negedge serial_resetn) begin
        if (!serial_resetn) begin
            sh0 <= '0;
            sh1 <= '0;
        end else begin
            sh0 <= {sh0[11:0], serial_data};
            sh1 <= {sh1[11:0], sh0[12]};
        end
    end

    always @(posedge serial_load or negedge serial_resetn) begin
        if (!serial_resetn) begin
            ld0 <= '0;
            ld1 <= '0;
        end else begin
            ld0 <= sh0;
            ld1 <= sh1;
        end
    end

    always @(posedge serial_clock) stream <= {stream[24:0], serial_data};
    always @(posedge serial_load) load_cnt++;

    typedef struct {
        logic [12:0] wr1;
        logic [12:0] wr0;
        logic [12:0] exp1;
        logic [12:0] exp0;
        int          exp_busy;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [0:0] a, input logic [12:0] d);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_wr = 1'b0;
        chk("wr_accept_no_reject", 32'(wr_reject), 32'd0);
    endtask

    task automatic run_xfer(input int hold, output int busy_cyc, output int dones, output int loads);
        int l0;
        l0         = load_cnt;
        busy_cyc   = 0;
        dones      = 0;
        xfer_start = 1'b1;
        for (int i = 0; i < 120; i++) begin
            step();
            cfg_wr = 1'b0;
            if (i + 1 >= hold) xfer_start = 1'b0;
            if (busy) busy_cyc++;
            if (done) dones++;
        end
        loads = load_cnt - l0;
    endtask

    initial begin
        vec_t vecs[4];
        int   bc, dn, lc;
        logic [12:0] rb_exp;

        vecs[0] = '{13'h1803, 13'h0403, 13'h1803, 13'h0403, 53};
        vecs[1] = '{13'h0ABC, 13'h1555, 13'h0ABC, 13'h1555, 53};
        vecs[2] = '{13'h0001, 13'h1000, 13'h0001, 13'h1000, 53};
        vecs[3] = '{13'h1FFF, 13'h0000, 13'h1FFF, 13'h0000, 53};

        rst            = 1'b1;
        gpio_defaults  = {13'h1FFF, 13'h0000};
        gpio_defaults3 = '0;
        cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0; xfer_start = 1'b0;
        cfg_wr3 = 1'b0; cfg_addr3 = '0; xfer3 = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_serial_clock", 32'(serial_clock), 32'd0);
        chk("rst_serial_resetn", 32'(serial_resetn), 32'd0);
        chk("rst_cfg_rdata", 32'(cfg_rdata), 32'd0);
        rst = 1'b0;
        #1;
        chk("resetn_held_until_edge", 32'(serial_resetn), 32'd0);
        step();
        chk("resetn_released", 32'(serial_resetn), 32'd1);

        // Transfer of power-on defaults with no writes.
        run_xfer(1, bc, dn, lc);
        chk("dflt_busy", 32'(bc), 32'd53);
        chk("dflt_done", 32'(dn), 32'd1);
        chk("dflt_pad1", 32'(ld1), 32'h1FFF);
        chk("dflt_pad0", 32'(ld0), 32'h0000);
        chk("dflt_stream", 32'(stream), 32'h3FFE000);

`ifdef GPIO_LOADER_READBACK_EN
        rb_exp = 13'h0ABC;
`else
        rb_exp = 13'h0000;
`endif
        wr(1'b0, 13'h0ABC);
        step();
        chk("readback_pad0", 32'(cfg_rdata), 32'(rb_exp));

        // Three-pad instance: out-of-range reject, valid write, readback, longer busy window.
        cfg_wr3 = 1'b1; cfg_addr3 = 2'd3; cfg_wdata = 13'h0777;
        step();
        cfg_wr3 = 1'b0;
        chk("d3_oob_reject", 32'(wr_reject3), 32'd1);
        step();
        chk("d3_reject_one_cycle", 32'(wr_reject3), 32'd0);
        cfg_wr3 = 1'b1; cfg_addr3 = 2'd2; cfg_wdata = 13'h0155;
        step();
        cfg_wr3 = 1'b0;
        chk("d3_valid_no_reject", 32'(wr_reject3), 32'd0);
        step();
`ifdef GPIO_LOADER_READBACK_EN
        rb_exp = 13'h0155;
`else
        rb_exp = 13'h0000;
`endif
        chk("d3_readback", 32'(cfg_rdata3), 32'(rb_exp));
        cfg_addr3 = 2'd3;
        step();
        chk("d3_readback_oob", 32'(cfg_rdata3), 32'd0);
        bc = 0;
        xfer3 = 1'b1;
        for (int i = 0; i < 250; i++) begin
            step();
            xfer3 = 1'b0;
            if (busy3) bc++;
        end
        chk("d3_busy_len", 32'(bc), 32'd158);

        for (int i = 0; i < 4; i++) begin
            wr(1'b1, vecs[i].wr1);
            wr(1'b0, vecs[i].wr0);
            run_xfer(1, bc, dn, lc);
            chk($sformatf("vec%0d_busy", i), 32'(bc), 32'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_done", i), 32'(dn), 32'd1);
            chk($sformatf("vec%0d_loads", i), 32'(lc), 32'd1);
            chk($sformatf("vec%0d_pad1", i), 32'(ld1), 32'(vecs[i].exp1));
            chk($sformatf("vec%0d_pad0", i), 32'(ld0), 32'(vecs[i].exp0));
            if (i == 0) begin
                chk("vec0_pad1_dm", 32'(ld1[12:10]), 32'b110);
                chk("vec0_pad1_mgmt_oeb", 32'(ld1[1:0]), 32'b11);
                chk("vec0_pad0_dm", 32'(ld0[12:10]), 32'b001);
            end
        end

        // Write and start in the same idle cycle: new word goes out.
        cfg_wr = 1'b1; cfg_addr = 1'b0; cfg_wdata = 13'h1234;
        run_xfer(1, bc, dn, lc);
        chk("same_cycle_pad0", 32'(ld0), 32'h1234);
        chk("same_cycle_pad1", 32'(ld1), 32'h1FFF);

        run_xfer(5, bc, dn, lc);
        chk("held_start_busy", 32'(bc), 32'd53);
        chk("held_start_done", 32'(dn), 32'd1);
        chk("held_start_loads", 32'(lc), 32'd1);

        // Write during busy is dropped and the transfer is untouched.
        xfer_start = 1'b1;
        step();
        xfer_start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        cfg_wr = 1'b1; cfg_addr = 1'b0; cfg_wdata = 13'h0AAA;
        step();
        cfg_wr = 1'b0;
        chk("busy_wr_reject", 32'(wr_reject), 32'd1);
        step();
        chk("busy_wr_reject_pulse", 32'(wr_reject), 32'd0);
        for (int i = 0; i < 100 && busy; i++) step();
        chk("busy_wr_xfer_ends", 32'(busy), 32'd0);
        chk("busy_wr_pad0", 32'(ld0), 32'h1234);
        chk("busy_wr_pad1", 32'(ld1), 32'h1FFF);
        run_xfer(1, bc, dn, lc);
        chk("busy_wr_storage_kept", 32'(ld0), 32'h1234);

        // Reset during bit 10 of SHIFT.
        wr(1'b1, 13'h0F0F);
        wr(1'b0, 13'h00FF);
        xfer_start = 1'b1;
        step();
        xfer_start = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("bit10_low_phase", 32'(serial_clock), 32'd0);
        chk("bit10_data", 32'(serial_data), 32'd1);
        step();
        chk("bit10_high_phase", 32'(serial_clock), 32'd1);
        lc = load_cnt;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_outputs", 32'({serial_clock, serial_data, serial_load, done, wr_reject}), 32'd0);
        chk("midrst_resetn", 32'(serial_resetn), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("midrst_no_load_pulse", 32'(load_cnt - lc), 32'd0);
        chk("midrst_chain_cleared", 32'({ld1, ld0}), 32'd0);
        step();
        chk("midrst_resetn_release", 32'(serial_resetn), 32'd1);
        run_xfer(1, bc, dn, lc);
        chk("midrst_dflt_pad1", 32'(ld1), 32'h1FFF);
        chk("midrst_dflt_pad0", 32'(ld0), 32'h0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
